accum4_seq: RTL and testbench

- Sequential accumulator stage that sits directly upstream of, and wraps, the team's 4-bit ripple-carry adder.
- Accepts a stream of NUM_OPS operands over a valid/ready handshake.
- Feeds each operand plus the running sum into the combinational adder, registers the sum, and tracks carry-out as sticky overflow.
- Presents the final sum with a one-cycle done pulse.

---
 rtl/accum4_seq_pkg.sv | 30 +++
 rtl/ripple_add4.sv | 23 ++
 rtl/accum4_seq.sv | 104 ++++++++++
 tb/tb_accum4_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/accum4_seq_pkg.sv
// Shared constants and types for the accum4_seq slice: state encodings,
// default geometry and the one-bit full-adder cell used by ripple_add4.
`ifndef ACCUM4_SEQ_DEFS
`define ACCUM4_SEQ_DEFS
`define ACCUM4_ST_IDLE  2'd0
`define ACCUM4_ST_ACCUM 2'd1
`define ACCUM4_ST_DONE  2'd2
`define ACCUM4_WIDTH    4
`define ACCUM4_NUM_OPS  4
`endif

package accum4_seq_pkg;

  localparam int DefWidth   = `ACCUM4_WIDTH;
  localparam int DefNumOps  = `ACCUM4_NUM_OPS;
  localparam int SliceWidth = 4;
  localparam int CntWidth   = 4;

  typedef enum logic [1:0] {
    IDLE  = `ACCUM4_ST_IDLE,
    ACCUM = `ACCUM4_ST_ACCUM,
    DONE  = `ACCUM4_ST_DONE
  } state_e;

  // One full-adder cell; result is {carry, sum}.
  function automatic logic [1:0] fullAdd(input logic a, input logic b, input logic ci);
    fullAdd = {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
  endfunction

endpackage

// File: rtl/ripple_add4.sv
// Purely combinational 4-bit ripple-carry adder built from a chain of
// full-adder cells; wider datapaths chain several of these.
module ripple_add4
  import accum4_seq_pkg::*;
(
  input  logic [SliceWidth-1:0] a,
  input  logic [SliceWidth-1:0] b,
  input  logic                  ci,
  output logic [SliceWidth-1:0] s,
  output logic                  co
);

  logic [SliceWidth:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < SliceWidth; i++) begin : g_fa
    assign {c[i+1], s[i]} = fullAdd(a[i], b[i], c[i]);
  end

  assign co = c[SliceWidth];

endmodule

// File: rtl/accum4_seq.sv
// Accumulates NUM_OPS operands from a valid/ready stream through the ripple
// adder, keeps a sticky carry-out and pulses done for one cycle at the end.
module accum4_seq
  import accum4_seq_pkg::*;
#(
  parameter int WIDTH   = DefWidth,
  parameter int NUM_OPS = DefNumOps
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int NumSlices = WIDTH / SliceWidth;
  localparam logic [CntWidth-1:0] LastOp = CntWidth'(NUM_OPS - 1);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    sum_q, sum_d;
  logic                cout_q, cout_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                cin_q, cin_d;

  logic [NumSlices:0]  carry;
  logic [WIDTH-1:0]    addSum;

  // The captured carry-in only enters the adder alongside the first operand.
  assign carry[0] = (cnt_q == '0) ? cin_q : 1'b0;

  for (genvar k = 0; k < NumSlices; k++) begin : g_slice
    ripple_add4 u_add (
      .a  (sum_q[k*SliceWidth +: SliceWidth]),
      .b  (x[k*SliceWidth +: SliceWidth]),
      .ci (carry[k]),
      .s  (addSum[k*SliceWidth +: SliceWidth]),
      .co (carry[k+1])
    );
  end

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    cin_d   = cin_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          sum_d   = '0;
          cout_d  = 1'b0;
          cnt_d   = '0;
          cin_d   = cin;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          sum_d  = addSum;
          cout_d = cout_q | carry[NumSlices];
          cnt_d  = cnt_q + CntWidth'(1);
          if (cnt_q == LastOp) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
      cin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
      cin_q   <= cin_d;
    end
  end

  assign in_ready = (state_q == ACCUM);
  assign busy     = (state_q == ACCUM);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;

endmodule

// File: tb/tb_accum4_seq.sv
// Directed bench for accum4_seq: a table of whole runs plus hand-written
// sequences for reset, ignored controls and result hold.
module tb_accum4_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cin;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] x;
  logic [3:0] sum;
  logic       cout;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic            cinV;
    logic [3:0][3:0] ops;
    logic [3:0][3:0] gaps;
    logic [3:0]      expSum;
    logic            expCout;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  accum4_seq #(.WIDTH(4), .NUM_OPS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cin      (cin),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .sum      (sum),
    .cout     (cout),
    .busy     (busy),
    .done     (done)
  );

  function automatic vec_t mkVec(input logic c, input logic [15:0] o, input logic [15:0] g,
                                 input logic [3:0] s, input logic co);
    vec_t v;
    v.cinV    = c;
    v.ops     = o;
    v.gaps    = g;
    v.expSum  = s;
    v.expCout = co;
    return v;
  endfunction

  // Drive one cycle of inputs, then let it be clocked in and settle.
  task automatic applyStimulus(input logic s, input logic c, input logic v, input logic [3:0] xv);
    start    = s;
    cin      = c;
    in_valid = v;
    x        = xv;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic runVector(input vec_t v, input int idx);
    logic [3:0] m;
    logic       mc;
    logic [4:0] t;
    m  = 4'h0;
    mc = 1'b0;
    applyStimulus(1'b1, v.cinV, 1'b0, 4'h0);
    checkOutput($sformatf("v%0d busy after start", idx), busy, 1);
    checkOutput($sformatf("v%0d in_ready after start", idx), in_ready, 1);
    checkOutput($sformatf("v%0d sum cleared", idx), sum, 0);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < int'(v.gaps[i]); g++) begin
        applyStimulus(1'b0, v.cinV, 1'b0, 4'h5);
        checkOutput($sformatf("v%0d gap busy", idx), busy, 1);
        checkOutput($sformatf("v%0d gap sum", idx), sum, m);
        checkOutput($sformatf("v%0d gap done", idx), done, 0);
      end
      t  = {1'b0, m} + {1'b0, v.ops[i]} + ((i == 0) ? {4'b0, v.cinV} : 5'd0);
      m  = t[3:0];
      mc = mc | t[4];
      applyStimulus(1'b0, v.cinV, 1'b1, v.ops[i]);
      if (i < 3) begin
        checkOutput($sformatf("v%0d op%0d sum", idx, i), sum, m);
        checkOutput($sformatf("v%0d op%0d done", idx, i), done, 0);
      end else begin
        checkOutput($sformatf("v%0d done pulse", idx), done, 1);
        checkOutput($sformatf("v%0d busy in done", idx), busy, 0);
        checkOutput($sformatf("v%0d in_ready in done", idx), in_ready, 0);
      end
    end
    checkOutput($sformatf("v%0d final sum", idx), sum, v.expSum);
    checkOutput($sformatf("v%0d final cout", idx), cout, v.expCout);
    checkOutput($sformatf("v%0d model cout", idx), cout, mc);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
    checkOutput($sformatf("v%0d done single cycle", idx), done, 0);
    checkOutput($sformatf("v%0d sum held in idle", idx), sum, v.expSum);
  endtask

  initial begin
    vecs[0] = mkVec(1'b0, 16'h4321, 16'h0000, 4'hA, 1'b0);
    vecs[1] = mkVec(1'b1, 16'hFFFF, 16'h0000, 4'hD, 1'b1);
    vecs[2] = mkVec(1'b0, 16'h1111, 16'h1520, 4'h4, 1'b0);
    vecs[3] = mkVec(1'b0, 16'h0088, 16'h0000, 4'h0, 1'b1);
    vecs[4] = mkVec(1'b1, 16'h0007, 16'h0103, 4'h8, 1'b0);
    vecs[5] = mkVec(1'b0, 16'h001F, 16'h0000, 4'h0, 1'b1);

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
    checkOutput("reset sum", sum, 0);
    checkOutput("reset cout", cout, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset in_ready", in_ready, 0);
    checkOutput("reset done", done, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      runVector(vecs[i], i);
    end

    // Result hold: operands offered in IDLE must not touch the held result.
    runVector(vecs[0], 10);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, logic'(i % 2), 4'h7);
      checkOutput("hold sum", sum, 4'hA);
      checkOutput("hold cout", cout, 0);
      checkOutput("hold done", done, 0);
      checkOutput("hold in_ready", in_ready, 0);
    end

    // Reset mid-run discards the partial result.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'h9);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'h6);
    checkOutput("pre-reset partial sum", sum, 4'hF);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
    rst = 1'b0;
    checkOutput("midrun reset sum", sum, 0);
    checkOutput("midrun reset cout", cout, 0);
    checkOutput("midrun reset busy", busy, 0);
    checkOutput("midrun reset in_ready", in_ready, 0);
    checkOutput("midrun reset done", done, 0);
    runVector(mkVec(1'b0, 16'h0069, 16'h0000, 4'hF, 1'b0), 20);

    // start pulsed during ACCUM must not restart the run.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'h2);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'h3);
    checkOutput("restart ignored sum", sum, 4'h6);
    checkOutput("restart ignored busy", busy, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'h4);
    checkOutput("restart ignored done", done, 1);
    checkOutput("restart ignored final sum", sum, 4'hA);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);

    // start held through DONE only takes effect once IDLE samples it.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'h1);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'h2);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'h3);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'h4);
    checkOutput("held start done", done, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0);
    checkOutput("held start back to idle busy", busy, 0);
    checkOutput("held start idle done", done, 0);
    checkOutput("held start idle sum", sum, 4'hA);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0);
    checkOutput("held start new run busy", busy, 1);
    checkOutput("held start new run sum", sum, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 4'h0);
    end
    checkOutput("held start run done", done, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
